// File: rtl/pq_pkg.sv
// Shared constants and types for the two-requester priority-queue scheduler.
// Keys sit in the top KEY_W bits of each word; a smaller key means higher priority.
package pq_pkg;

  localparam int PQ_DEPTH  = 4;
  localparam int PQ_DATA_W = 64;
  localparam int PQ_KEY_W  = 32;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_POP    = 1'b1;

  localparam int FLAG_EVICT = 0;
  localparam int FLAG_EMPTY = 1;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_EVICT = 2'b01;
  localparam logic [1:0] RSP_EMPTY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [PQ_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/pq_sorted_insert.sv
// Combinational stable insert of one slot into a key-sorted slot vector.
// The slot pushed past the last position comes out on overflow (all-zero when not full).
module pq_sorted_insert
  import pq_pkg::*;
#(
  parameter int DEPTH  = PQ_DEPTH,
  parameter int DATA_W = PQ_DATA_W,
  parameter int KEY_W  = PQ_KEY_W
) (
  input  logic [DEPTH-1:0][DATA_W:0] slots,
  input  logic [DATA_W:0]            new_slot,
  output logic [DEPTH-1:0][DATA_W:0] sorted,
  output logic [DATA_W:0]            overflow
);

  logic [KEY_W-1:0] new_key;
  logic [DEPTH-1:0] keep;

  assign new_key = new_slot[DATA_W-1 -: KEY_W];

  // keep[i]: slot i is valid with key <= new key, so it stays ahead (FIFO among ties)
  always_comb begin
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = slots[i][DATA_W] && (slots[i][DATA_W-1 -: KEY_W] <= new_key);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign sorted[i] = keep[i] ? slots[i] : new_slot;
    end else begin : g_body
      assign sorted[i] = keep[i]   ? slots[i] :
                         keep[i-1] ? new_slot : slots[i-1];
    end
  end

  assign overflow = keep[DEPTH-1] ? new_slot : slots[DEPTH-1];

endmodule

// File: rtl/pq_sched.sv
// Round-robin two-requester front end for a DEPTH-slot sorted priority queue.
// One command at a time: IDLE accepts, EXEC updates the array, RESP holds the reply.
module pq_sched
  import pq_pkg::*;
#(
  parameter int DEPTH  = PQ_DEPTH,
  parameter int DATA_W = PQ_DATA_W,
  parameter int KEY_W  = PQ_KEY_W
) (
  input  logic                       system1000,
  input  logic                       system1000_rstn,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_op,
  input  logic [2*DATA_W-1:0]        req_data,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [1:0]                 rsp_flag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshake: a command moves when req_valid[r] & req_ready[r]; a response
  // moves when rsp_valid[r] & rsp_ready[r]. Both ready/valid vectors are one-hot.
  state_t                    state;
  logic                      last_grant;
  logic                      gnt;
  logic                      cmd_op;
  logic [DATA_W-1:0]         cmd_data;
  logic [DEPTH-1:0][DATA_W:0] slots;
  logic [DEPTH-1:0][DATA_W:0] ins_slots;
  logic [DEPTH-1:0][DATA_W:0] pop_slots;
  logic [DATA_W:0]           ins_over;
  logic                      winner;
  logic                      win_op;
  logic [DATA_W-1:0]         win_data;
  logic                      full;
  logic                      empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // With both requesters valid, the one not granted last wins
  always_comb begin
    winner = req_valid[1];
    if (&req_valid) begin
      winner = ~last_grant;
    end
  end

  assign win_op   = winner ? req_op[1] : req_op[0];
  assign win_data = winner ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

  always_comb begin
    req_ready = 2'b00;
    if (system1000_rstn && state == ST_IDLE && |req_valid) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == ST_RESP) begin
      rsp_valid = gnt ? 2'b10 : 2'b01;
    end
  end

  pq_sorted_insert #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W)
  ) u_sorted_insert (
    .slots    (slots),
    .new_slot ({1'b1, cmd_data}),
    .sorted   (ins_slots),
    .overflow (ins_over)
  );

  // Pop shifts everything toward slot 0 and zero-fills the tail
  for (genvar i = 0; i < DEPTH; i++) begin : g_pop
    if (i == DEPTH-1) begin : g_tail
      assign pop_slots[i] = '0;
    end else begin : g_shift
      assign pop_slots[i] = slots[i+1];
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cmd_op     <= OP_INSERT;
      cmd_data   <= '0;
      slots      <= '0;
      count      <= '0;
      rsp_data   <= '0;
      rsp_flag   <= RSP_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt        <= winner;
            last_grant <= winner;
            cmd_op     <= win_op;
            cmd_data   <= win_data;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_RESP;
          if (cmd_op == OP_INSERT) begin
            slots <= ins_slots;
            if (full && ins_over[DATA_W]) begin
              rsp_data <= ins_over[DATA_W-1:0];
              rsp_flag <= RSP_EVICT;
            end else begin
              count    <= count + CNT_W'(1);
              rsp_data <= '0;
              rsp_flag <= RSP_NONE;
            end
          end else if (empty) begin
            rsp_data <= '0;
            rsp_flag <= RSP_EMPTY;
          end else begin
            rsp_data <= slots[0][DATA_W-1:0];
            slots    <= pop_slots;
            count    <= count - CNT_W'(1);
            rsp_flag <= RSP_NONE;
          end
        end
        ST_RESP: begin
          if (rsp_ready[gnt]) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pq_sched.md
# pq_sched

Two-requester scheduler for the 4-slot priority-queue register path. It arbitrates insert/pop commands from two requesters round-robin and sequences one command at a time through the sorted slot array. Each slot is 65 bits: a valid flag plus a 64-bit word, with the smaller key at higher priority. It returns a per-requester response (popped word, evicted word, or ack) over a valid/ready handshake, and sits between the client logic and the priority-queue datapath.

## Interface
- DEPTH, 4, number of queue slots (≥2).
- DATA_W, 64, word width; slot width is DATA_W+1 (bit DATA_W = valid).
- KEY_W, 32, key = word[DATA_W-1 -: KEY_W]; unsigned compare, smaller = higher priority.
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester command valid.
- req_op  in  2  per-requester op: 0 = insert, 1 = pop.
- req_data  in  2*DATA_W  per-requester insert word; requester r uses bits [r*DATA_W +: DATA_W].
- req_ready  out  2  one-hot accept strobe; a command transfers when req_valid[r] & req_ready[r].
- rsp_valid  out  2  one-hot response valid to the granted requester.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DATA_W  popped or evicted word; 0 for a plain insert ack or an empty pop.
- rsp_flag  out  2  bit0 = evict, bit1 = empty.
- count  out  $clog2(DEPTH+1)  number of valid slots.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is high only for the winner g; winner = requester with req_valid set; if both are valid, the requester not granted last wins.
  - Last-grant pointer resets to 1, so requester 0 wins first.
  - On transfer: latch g, op and data, then go to EXEC. With no valid requester, stay in IDLE.
- EXEC (one cycle): update the array and load the response registers, then go to RESP.
  - Insert, count<DEPTH: place the word after all valid slots with key ≤ the new key (stable, FIFO among ties); shift later slots toward DEPTH-1; count+1; rsp 0/flag 00.
  - Insert, count==DEPTH: insert the same way, then evict the entry that ends beyond slot DEPTH-1. If the new key ≥ the slot DEPTH-1 key, the new word itself is evicted. rsp_data = evicted word, flag 01, count unchanged.
  - Pop, count>0: return slot 0, shift all slots toward 0, clear slot DEPTH-1 valid, count-1, flag 00.
  - Pop, count==0: array unchanged, rsp_data 0, flag 10.
- RESP: hold rsp_valid[g], rsp_data and rsp_flag stable until rsp_ready[g]; in that cycle return to IDLE. No new command is accepted in EXEC or RESP.
- Invariant: slots 0..count-1 are valid and key-sorted ascending; slots count..DEPTH-1 have valid=0 and data 0.

## Timing
- Reset (async assert, sync release):
  - Outputs: req_ready 0, rsp_valid 0, rsp_data 0, rsp_flag 0, count 0.
  - Internals: all slots 0, state IDLE, pointer=1.
- Reset mid-command: the in-flight command and response are discarded and the array is cleared.
- req_ready is combinational from state, pointer and req_valid. It is never high outside IDLE and is never high on both bits.
- Latency:
  - Command accepted at edge T.
  - Array and count updated at edge T+1.
  - rsp_valid high from cycle T+1 (registered, after the EXEC edge).
  - Earliest next accept is the cycle after the response handshake, so the back-to-back throughput is one command per 3 cycles.
- rsp_ready asserted before rsp_valid has no effect. A response is never dropped while rsp_valid=1.
- count is registered and reflects completed commands only.

## Structure
- Package pq_pkg holds:
  - DEPTH, DATA_W, KEY_W defaults.
  - OP_INSERT=0, OP_POP=1.
  - FLAG_EVICT=bit0, FLAG_EMPTY=bit1.
  - The state enum (IDLE/EXEC/RESP).
  - A slot typedef {valid, data}.
- One combinational sub-module, pq_sorted_insert:
  - Inputs: DEPTH-slot vector and one slot.
  - Outputs: (DEPTH)-slot sorted result plus the overflow slot.
  - Implementation: per-slot compare plus shift mux.
- The pop shift stays inline: a slot-vector shift toward 0 with a zero fill.

## Test plan
- Reset, then requester 0 inserts keys 0x30, 0x10, 0x20 (low word = tag); requester 0 then pops 3 times. Expected: rsp_data keys 0x10, 0x20, 0x30, flag 00, count 3→0.
- Both requesters valid continuously after reset, both popping on an empty queue. Expected: grants alternate 0,1,0,1; every response has flag 10, rsp_data 0; req_ready is never 2'b11.
- Fill with keys 0x10, 0x20, 0x30, 0x40, then insert 0x25. Expected: flag 01, rsp_data key 0x40, slots 0x10, 0x20, 0x25, 0x30. Then insert 0x50: it is evicted itself and the array is unchanged.
- Insert key 0x20 with tag A, then key 0x20 with tag B, then pop twice. Expected: tag A first, then tag B.
- Hold rsp_ready[g]=0 for 5 cycles. Expected: rsp_valid, rsp_data and rsp_flag stay stable; req_ready stays 0 despite the other requester being valid; the other requester is served in the cycle after the handshake.
- Assert system1000_rstn low while in RESP with count=3. Expected: outputs drop to reset values immediately; after release, a pop returns flag 10.
